if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset (bits[1:0] SHALL be 0).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-004 The block SHALL have port rom_ce, output, 1, the instruction-memory chip enable (1 = enabled).
REQ-005 The block SHALL have port rom_addr, output, 32, the byte fetch address (PC).
REQ-006 The block SHALL have port rom_inst, input, 32, the instruction word, valid combinationally in the same cycle as rom_addr.
REQ-007 The block SHALL have port stall_i, input, 1, the pipeline-control fetch hold.
REQ-008 The block SHALL have port branch_flag_i, input, 1, the redirect strobe.
REQ-009 The block SHALL have port branch_target_i, input, 32, the redirect address.
REQ-010 The block SHALL have port id_valid_o, output, 1, the decode-side valid.
REQ-011 The block SHALL have port id_ready_i, input, 1, the decode-side ready.
REQ-012 The block SHALL have port id_pc_o, output, 32, the PC of the presented instruction.
REQ-013 The block SHALL have port id_inst_o, output, 32, the presented instruction.
REQ-014 The block SHALL have port fetch_cnt_o, output, 32, the count of accepted fetches.

Function
REQ-015 The state machine SHALL have two states, IDLE and FETCH; reset enters IDLE; IDLE moves to FETCH unconditionally on the next edge; FETCH stays in FETCH until reset.
REQ-016 rom_ce SHALL be 1 only in FETCH, and rom_addr SHALL equal the PC register in every state.
REQ-017 The block SHALL contain a 2-entry FIFO of {pc, inst} pairs.
REQ-018 id_valid_o SHALL be 1 iff the FIFO is not empty; id_pc_o and id_inst_o SHALL show the FIFO head and be 0 when the FIFO is empty.
REQ-019 A pop SHALL occur in a cycle iff id_valid_o=1 and id_ready_i=1.
REQ-020 A push of {PC, rom_inst} SHALL occur iff all hold: state=FETCH, stall_i=0, branch_flag_i=0, and the FIFO is not full or a pop occurs in the same cycle.
REQ-021 On a push, PC SHALL advance by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), and fetch_cnt_o SHALL increment modulo 2^32.
REQ-022 A push and a pop in the same cycle SHALL leave the occupancy unchanged; with occupancy 1, the pushed entry SHALL become the head on the next cycle.
REQ-023 Without a push, PC SHALL hold.
REQ-024 branch_flag_i=1 SHALL take priority over everything else: the FIFO is cleared (occupancy 0 next cycle), no push occurs, and PC loads {branch_target_i[31:2], 2'b00}.
REQ-025 A pop in the same cycle as a branch SHALL still be reported as consumed; the entry is discarded by the flush.
REQ-026 branch_flag_i in IDLE SHALL load PC from the target and SHALL NOT alter the state transition.
REQ-027 stall_i=1 SHALL block the push only; pops continue; stall_i and branch_flag_i both high SHALL behave as a branch.
REQ-028 Throughput SHALL be one instruction per cycle with id_ready_i held 1, and the fetch-to-present latency SHALL be 1 cycle (push at edge N, visible after edge N).

Reset
REQ-029 On rst_n=0 the block SHALL immediately, without waiting for a clock edge, set: state=IDLE, PC=RESET_PC, FIFO empty, fetch_cnt_o=0, rom_ce=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and any branch in progress.
REQ-031 The first rom_ce=1 cycle SHALL be the second rising edge after rst_n deasserts.

Verification
REQ-032 Reset, then id_ready_i=1 and a ROM holding word k = 32'h1000_0000+k -> the bench sees pc 0,4,8,... with inst 0x10000000,0x10000001,... on consecutive cycles, and fetch_cnt_o matches the number of transfers.
REQ-033 id_ready_i=0 for 5 cycles -> the FIFO fills at 2 entries, PC stops at 8, rom_addr holds 8, and no instruction is lost or duplicated after ready returns.
REQ-034 A branch to 32'h0000_0103 while 2 entries are buffered -> id_valid_o=0 the next cycle, and the next presented pc is 0x100.
REQ-035 stall_i=1 for 3 cycles with id_ready_i=1 -> the buffered entries drain, PC is frozen, fetch_cnt_o is frozen, and fetching resumes at the same PC.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> the bench sees pcs FFFFFFF8, FFFFFFFC, 00000000.
REQ-037 rst_n pulsed low mid-stream -> the outputs clear asynchronously, and fetching restarts at RESET_PC after the IDLE cycle.

Source files
------------

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
//   Instruction fetch stage. Drives the PC onto the instruction ROM, captures
//   {pc, inst} pairs into a 2-entry FIFO and presents the FIFO head to decode
//   with a valid/ready handshake. Branch redirects flush the FIFO and reload
//   the PC; stall_i holds off new fetches while decode keeps draining.
//
// Ports
//   clk              clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   rom_ce           instruction memory enable (1 while fetching)
//   rom_addr         byte fetch address (current PC)
//   rom_inst         instruction word for rom_addr, same cycle
//   stall_i          hold fetch (pops still allowed)
//   branch_flag_i    redirect strobe, highest priority
//   branch_target_i  redirect address (low two bits ignored)
//   id_valid_o       FIFO head valid
//   id_ready_i       decode accepts head this cycle
//   id_pc_o          PC of presented instruction (0 when empty)
//   id_inst_o        presented instruction (0 when empty)
//   fetch_cnt_o      number of instructions pushed since reset
//
// State table
//   state | meaning
//   IDLE  | one cycle after reset, ROM disabled, no fetches
//   FETCH | ROM enabled, fetching whenever FIFO has room
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state_q;
    logic        rom_ce_q;

    logic [31:0] pc_q,        pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [1:0]  occ_q,       occ_d;
    logic        rd_ptr_q,    rd_ptr_d;
    logic        wr_ptr_q,    wr_ptr_d;
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];

    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;

    // Only the word-aligned part of the target is used.
    logic [1:0]  unused_tgt_lsb;
    assign unused_tgt_lsb = branch_target_i[1:0];

    assign fifo_empty = (occ_q == 2'd0);
    assign fifo_full  = (occ_q == 2'd2);
    assign pop        = !fifo_empty && id_ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push       = (state_q == FETCH) && !stall_i && !branch_flag_i &&
                        (!fifo_full || pop);

    // Control FSM with registered ROM enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rom_ce_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= FETCH;
                    rom_ce_q <= 1'b1;
                end
                FETCH: begin
                    state_q  <= FETCH;
                    rom_ce_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    rom_ce_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        occ_d       = occ_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (branch_flag_i) begin
            // Flush wins over any pop/push in the same cycle.
            pc_d     = {branch_target_i[31:2], 2'b00};
            occ_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                pc_d        = pc_q + 32'd4;
                fetch_cnt_d = fetch_cnt_q + 32'd1;
                wr_ptr_d    = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            fetch_cnt_q    <= 32'd0;
            occ_q          <= 2'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            fifo_pc_q[0]   <= 32'd0;
            fifo_pc_q[1]   <= 32'd0;
            fifo_inst_q[0] <= 32'd0;
            fifo_inst_q[1] <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= pc_q;
                fifo_inst_q[wr_ptr_q] <= rom_inst;
            end
        end
    end

    assign rom_ce      = rom_ce_q;
    assign rom_addr    = pc_q;
    assign fetch_cnt_o = fetch_cnt_q;
    assign id_valid_o  = !fifo_empty;
    assign id_pc_o     = fifo_empty ? 32'd0 : fifo_pc_q[rd_ptr_q];
    assign id_inst_o   = fifo_empty ? 32'd0 : fifo_inst_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;

    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] fetch_cnt;

    logic        rom_ce_w;
    logic [31:0] rom_addr_w;
    logic [31:0] rom_inst_w;
    logic        id_valid_w;
    logic [31:0] id_pc_w;
    logic [31:0] id_inst_w;
    logic [31:0] fetch_cnt_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM: word k holds 0x1000_0000 + k
    assign rom_inst   = 32'h1000_0000 + {2'b00, rom_addr[31:2]};
    assign rom_inst_w = 32'h1000_0000 + {2'b00, rom_addr_w[31:2]};

    if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
        .id_valid_o(id_valid), .id_ready_i(rdy),
        .id_pc_o(id_pc), .id_inst_o(id_inst), .fetch_cnt_o(fetch_cnt)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce_w), .rom_addr(rom_addr_w), .rom_inst(rom_inst_w),
        .stall_i(1'b0), .branch_flag_i(1'b0), .branch_target_i(32'h0),
        .id_valid_o(id_valid_w), .id_ready_i(1'b1),
        .id_pc_o(id_pc_w), .id_inst_o(id_inst_w), .fetch_cnt_o(fetch_cnt_w)
    );

    wire [129:0] obs_vec = {rom_ce, rom_addr, id_valid, id_pc, id_inst, fetch_cnt};

    // ---------------- reference model ----------------
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_fetch;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    function automatic logic [129:0] exp_vec();
        logic [31:0] hp = 32'd0;
        logic [31:0] hi = 32'd0;
        if (mq.size() != 0) begin
            hp = mq[0][63:32];
            hi = mq[0][31:0];
        end
        return {m_fetch, m_pc, (mq.size() != 0), hp, hi, m_cnt};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        m_fetch = 1'b0;
    endtask

    // Advance one clock edge, update the model from the inputs that were
    // applied before the edge, then settle 1 time unit past the edge.
    task automatic tick();
        bit pop;
        @(posedge clk);
        pop = (mq.size() != 0) && rdy;
        if (br) begin
            mq.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_fetch && !stall && mq.size() < 2) begin
                mq.push_back({m_pc, rom_word(m_pc)});
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        m_fetch = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 32'h0;
        rdy   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0; rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== 130'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h want 0", obs_vec);
        end
        n_cmp++;
        if (rom_addr_w !== 32'hFFFF_FFF8 || rom_ce_w !== 1'b0 || id_valid_w !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wrap_pc: got addr %h ce %b v %b want FFFFFFF8 0 0",
                     rom_addr_w, rom_ce_w, id_valid_w);
        end
        do_reset();
    endtask

    task automatic test_stream();
        int n_xfer = 0;
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (id_valid && rdy) n_xfer++;
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL stream cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
            if (i == 0) begin
                n_cmp++;
                if (rom_ce !== 1'b1 || id_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL stream_first_ce: got ce %b v %b want 1 0", rom_ce, id_valid);
                end
            end
            if (i >= 1) begin
                n_cmp++;
                if (id_pc !== 32'(4 * (i - 1)) || id_inst !== 32'h1000_0000 + 32'(i - 1)) begin
                    n_err++;
                    $display("FAIL stream_seq cyc %0d: got pc %h inst %h want %h %h",
                             i, id_pc, id_inst, 32'(4 * (i - 1)), 32'h1000_0000 + 32'(i - 1));
                end
            end
        end
        n_cmp++;
        if (fetch_cnt !== 32'(n_xfer) + {31'd0, id_valid}) begin
            n_err++;
            $display("FAIL stream_cnt: got %0d want %0d", fetch_cnt, n_xfer + int'(id_valid));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] next_pc = 32'h0;
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        n_cmp++;
        if (rom_addr !== 32'h8 || id_pc !== 32'h0 || fetch_cnt !== 32'd2 || id_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_full: got addr %h pc %h cnt %0d v %b want 8 0 2 1",
                     rom_addr, id_pc, fetch_cnt, id_valid);
        end
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (id_valid) begin
                n_cmp++;
                if (id_pc !== next_pc) begin
                    n_err++;
                    $display("FAIL bp_order cyc %0d: got %h want %h", i, id_pc, next_pc);
                end
                next_pc = next_pc + 32'd4;
            end
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL bp_drain cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        // branch while in IDLE
        do_reset();
        br = 1'b1; tgt = 32'h0000_0207;
        tick();
        br = 1'b0;
        n_cmp++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0000_0204) begin
            n_err++;
            $display("FAIL br_idle: got ce %b addr %h want 1 00000204", rom_ce, rom_addr);
        end
        // branch with two entries buffered
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        br = 1'b1; tgt = 32'h0000_0103;
        tick();
        br = 1'b0;
        n_cmp++;
        if (id_valid !== 1'b0 || rom_addr !== 32'h100 || obs_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL br_flush: got v %b addr %h vec %h want 0 100 %h",
                     id_valid, rom_addr, obs_vec, exp_vec());
        end
        rdy = 1'b1;
        tick();
        n_cmp++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h1000_0040) begin
            n_err++;
            $display("FAIL br_target: got v %b pc %h inst %h want 1 100 10000040",
                     id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc_hold;
        logic [31:0] cnt_hold;
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        pc_hold  = rom_addr;
        cnt_hold = fetch_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec() || rom_addr !== pc_hold || fetch_cnt !== cnt_hold) begin
                n_err++;
                $display("FAIL stall cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        n_cmp++;
        if (id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_drain: got v %b want 0", id_valid);
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (id_valid !== 1'b1 || id_pc !== pc_hold) begin
            n_err++;
            $display("FAIL stall_resume: got v %b pc %h want 1 %h", id_valid, id_pc, pc_hold);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset();
        rdy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (id_valid_w !== 1'b1 || id_pc_w !== exp_pc[i] || id_inst_w !== rom_word(exp_pc[i])) begin
                n_err++;
                $display("FAIL wrap %0d: got v %b pc %h inst %h want 1 %h %h",
                         i, id_valid_w, id_pc_w, id_inst_w, exp_pc[i], rom_word(exp_pc[i]));
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rdy = 1'b1;
        br = 1'b1; tgt = 32'h0000_0400;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== 130'd0) begin
            n_err++;
            $display("FAIL midreset_async: got %h want 0", obs_vec);
        end
        @(posedge clk);
        #1;
        br = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL midreset_restart cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
            if (i == 1) begin
                n_cmp++;
                if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
                    n_err++;
                    $display("FAIL midreset_pc: got v %b pc %h want 1 0", id_valid, id_pc);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            br    = ($urandom_range(0, 15) == 0);
            tgt   = $urandom;
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        stall = 1'b0;
        br    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_stall();
        test_wrap();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
